// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory among N_CORES requesters.
// Define DMEM_ARB_BUSY_CNT_EN to add the saturating busy_cycles counter output.
module dmem_arbiter #(
  parameter int N_CORES = 4,
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           NoC,
  input  logic [N_CORES-1:0]    req,
  input  logic [N_CORES-1:0]    we,
  input  logic [N_CORES*AW-1:0] addr,
  input  logic [N_CORES*DW-1:0] wdata,
  output logic [N_CORES-1:0]    gnt,
  output logic [N_CORES-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [DW-1:0]         mem_wdata,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  busy
`ifdef DMEM_ARB_BUSY_CNT_EN
  ,
  output logic [31:0]           busy_cycles
`endif
);

  localparam int IW = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        last, win;
  logic                 found;
  logic [15:0]          eff_noc;
  logic [N_CORES-1:0]   elig, win_oh, cur_oh;
  logic                 cur_we;
  logic [CW-1:0]        cnt;
  logic                 sel_we;
  logic [AW-1:0]        sel_addr;
  logic [DW-1:0]        sel_wdata;

  always_comb begin
    if (NoC == 16'd0)                eff_noc = 16'd1;
    else if (NoC > 16'(N_CORES))     eff_noc = 16'(N_CORES);
    else                             eff_noc = NoC;
  end

  always_comb begin
    elig = '0;
    for (int i = 0; i < N_CORES; i++)
      elig[i] = req[i] && (i < int'(eff_noc));
  end

  // Two passes: indices above last first, then wrap around to those at or below it.
  always_comb begin
    found = 1'b0;
    win   = last;
    for (int i = 0; i < N_CORES; i++)
      if (!found && elig[i] && (i > int'(last))) begin
        found = 1'b1;
        win   = IW'(i);
      end
    for (int i = 0; i < N_CORES; i++)
      if (!found && elig[i] && (i <= int'(last))) begin
        found = 1'b1;
        win   = IW'(i);
      end
  end

  always_comb begin
    win_oh    = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++)
      if (IW'(i) == win) begin
        win_oh[i] = 1'b1;
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= IW'(N_CORES - 1);
      cur_oh    <= '0;
      cur_we    <= 1'b0;
      cnt       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      state  <= state_nxt;
      gnt    <= '0;
      rvalid <= '0;
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      busy   <= (state_nxt != IDLE);
      case (state)
        IDLE: if (found) begin
          last      <= win;
          cur_oh    <= win_oh;
          cur_we    <= sel_we;
          gnt       <= win_oh;
          mem_en    <= 1'b1;
          mem_we    <= sel_we;
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
        end
        ISSUE: cnt <= CW'(MEM_LAT - 1);
        // Last WAIT cycle captures read data so it lines up with the rvalid pulse.
        WAIT: if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          rvalid <= cur_oh;
          if (!cur_we) rdata <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

`ifdef DMEM_ARB_BUSY_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      busy_cycles <= '0;
    else if (busy && (busy_cycles != 32'hFFFF_FFFF))
      busy_cycles <= busy_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a transaction-level model predicts grants and completions into
// expected queues, and a negedge monitor pops and compares them against the DUT every cycle.
module tb_dmem_arbiter;
  localparam int N   = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int TAB = 256;

  // Packed expectation records so the queues are plain logic vectors.
  typedef struct packed {
    logic [31:0]   cyc;
    logic [7:0]    core;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } gexp_t;
  typedef struct packed {
    logic [31:0]   cyc;
    logic [7:0]    core;
    logic [DW-1:0] rdata;
  } rexp_t;

  logic               clk;
  logic               rst;
  logic [15:0]        NoC;
  logic [N-1:0]       req, we;
  logic [N*AW-1:0]    addr;
  logic [N*DW-1:0]    wdata;
  logic [N-1:0]       gnt, rvalid;
  logic [DW-1:0]      rdata;
  logic               mem_en, mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata = '0;
  logic               busy;
`ifdef DMEM_ARB_BUSY_CNT_EN
  logic [31:0]        busy_cycles;
  int                 exp_bc = 0;
`endif

  gexp_t              gq[$];
  rexp_t              rq[$];
  logic [DW-1:0]      rd_tab[TAB];
  int                 cyc = 0;
  int                 n_tests = 0;
  int                 n_fail = 0;
  int                 m_last, m_free_at, busy_lo, busy_hi, bc_clear_at, n_dec;
  logic [DW-1:0]      m_last_rd;
  bit                 mon_on;
  int                 mon_from;
  int                 granted_at[N];
  int                 pend_since[N];

  dmem_arbiter #(.N_CORES(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .NoC(NoC), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_BUSY_CNT_EN
    , .busy_cycles(busy_cycles)
`endif
  );

  // ---------------- clock / reset / memory stub ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory read data is a known function of the cycle, so the exact sample cycle is checked.
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_tab[cyc % TAB];
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Called once per cycle with that cycle's inputs; serialises accesses and applies
  // round-robin with the NoC mask using plain index arithmetic.
  task automatic model_step();
    int c, eff, w, idx;
    gexp_t g;
    rexp_t r;
    c = cyc;
    if (rst) begin
      while (gq.size() > 0 && int'(gq[gq.size()-1].cyc) > c) void'(gq.pop_back());
      while (rq.size() > 0 && int'(rq[rq.size()-1].cyc) > c) void'(rq.pop_back());
      if (busy_hi > c) busy_hi = c;
      m_free_at   = c + 1;
      m_last      = N - 1;
      m_last_rd   = '0;
      bc_clear_at = c + 1;
      if (!mon_on) begin
        mon_on   = 1'b1;
        mon_from = c + 1;
      end
      return;
    end
    if (!mon_on || c < m_free_at) return;
    eff = (NoC == 0) ? 1 : ((int'(NoC) > N) ? N : int'(NoC));
    w = -1;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (w < 0 && req[idx] && idx < eff) w = idx;
    end
    if (w < 0) return;
    g.cyc   = 32'(c + 1);
    g.core  = 8'(w);
    g.we    = we[w];
    g.addr  = addr[w*AW +: AW];
    g.wdata = wdata[w*DW +: DW];
    gq.push_back(g);
    if (!we[w]) m_last_rd = rd_tab[(c + 1 + LAT) % TAB];
    r.cyc   = 32'(c + 2 + LAT);
    r.core  = 8'(w);
    r.rdata = m_last_rd;
    rq.push_back(r);
    busy_lo       = c + 1;
    busy_hi       = c + 2 + LAT;
    m_free_at     = c + 3 + LAT;
    m_last        = w;
    granted_at[w] = c + 1;
    n_dec++;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    logic [N-1:0] exp_g, exp_r;
    logic exp_we, have_g, have_r, exp_busy;
    if (mon_on && cyc >= mon_from) begin
      exp_g = '0; exp_r = '0; exp_we = 1'b0; have_g = 1'b0; have_r = 1'b0;
      g = '0; r = '0;
      if (gq.size() > 0 && int'(gq[0].cyc) == cyc) begin
        g = gq.pop_front();
        have_g = 1'b1;
        exp_g = N'(1) << g.core;
        exp_we = g.we;
      end
      chk("gnt", 32'(gnt), 32'(exp_g));
      chk("mem_en", 32'(mem_en), 32'(have_g));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (have_g) begin
        chk("mem_addr", 32'(mem_addr), 32'(g.addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
      end
      if (rq.size() > 0 && int'(rq[0].cyc) == cyc) begin
        r = rq.pop_front();
        have_r = 1'b1;
        exp_r = N'(1) << r.core;
      end
      chk("rvalid", 32'(rvalid), 32'(exp_r));
      if (have_r) chk("rdata", 32'(rdata), 32'(r.rdata));
      exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", 32'(busy), 32'(exp_busy));
`ifdef DMEM_ARB_BUSY_CNT_EN
      if (cyc == bc_clear_at) exp_bc = 0;
      chk("busy_cycles", busy_cycles, 32'(exp_bc));
      if (exp_busy) exp_bc++;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_dec(input int bound);
    int d0;
    d0 = n_dec;
    for (int k = 0; k < bound && n_dec == d0; k++) step(1);
  endtask

  // Requesters hold their fields until granted, then drop or re-request with new fields.
  task automatic rand_drive();
    for (int i = 0; i < N; i++) begin
      if (!req[i]) begin
        if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          we[i] = 1'($urandom_range(0, 1));
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*DW +: DW] = DW'($urandom);
          pend_since[i] = cyc;
        end
      end else if (granted_at[i] > pend_since[i] && cyc > granted_at[i]) begin
        if ($urandom_range(0, 1) == 0) begin
          req[i] = 1'b0;
        end else begin
          we[i] = 1'($urandom_range(0, 1));
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*DW +: DW] = DW'($urandom);
          pend_since[i] = cyc;
        end
      end else if ($urandom_range(0, 15) == 0) begin
        req[i] = 1'b0;
      end
    end
    if ($urandom_range(0, 39) == 0) NoC = 16'($urandom_range(0, 6));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < TAB; i++) rd_tab[i] = DW'($urandom);
    for (int i = 0; i < N; i++) begin
      granted_at[i] = -1;
      pend_since[i] = 0;
    end
    m_last = N - 1; m_free_at = 0; busy_lo = 1; busy_hi = 0; bc_clear_at = 0;
    n_dec = 0; m_last_rd = '0; mon_on = 1'b0; mon_from = 0;
    rst = 1'b1; NoC = 16'd4; req = '0; we = '0; addr = '0; wdata = '0;
    @(posedge clk);
    #1;
    step(2);
    rst = 1'b0;
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);

    // single read from core 0
    addr[0 +: AW] = 16'h0010;
    req = 4'b0001;
    wait_dec(10);
    req = '0;
    step(8);

    // all cores requesting continuously
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(16'h0100 + i);
    req = 4'b1111;
    step(24);

    // masked requesters, then widen NoC
    NoC = 16'd2;
    req = 4'b1100;
    step(12);
    NoC = 16'd4;
    step(8);
    req = '0;
    step(6);

    // write from core 1
    we[1] = 1'b1;
    addr[1*AW +: AW] = 16'h0004;
    wdata[1*DW +: DW] = 16'h1234;
    req = 4'b0010;
    wait_dec(10);
    req = '0;
    we = '0;
    step(8);

    // reset in the first WAIT cycle of a core-2 access
    req = 4'b0100;
    wait_dec(10);
    req = '0;
    step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_mem_addr", 32'(mem_addr), 32'h0);
    chk("midrst_rdata", 32'(rdata), 32'h0);
    req = 4'b1111;
    step(12);
    req = '0;
    step(6);

    // randomized traffic with occasional NoC changes and resets
    for (int i = 0; i < N; i++) begin
      granted_at[i] = -1;
      pend_since[i] = cyc;
    end
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(0, 199) == 0);
      rand_drive();
      step(1);
    end
    rst = 1'b0;
    req = '0;
    NoC = 16'd4;
    step(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Round-robin arbiter that shares the single-port data memory among up to `N_CORES` processing cores of the multi-core processor. Each core raises a request with address, data and write-enable. The arbiter grants one core at a time, drives the memory port, waits the fixed memory latency, then returns read data and a completion pulse. `NoC`, the number of active cores driven by the top-level control, masks requesters so that unused cores can never win a grant.

## Interface
- `N_CORES`, default 4: number of requester ports, range 1..16.
- `AW`, default 16: address width.
- `DW`, default 16: data width.
- `MEM_LAT`, default 2: cycles from `mem_en` to valid `mem_rdata`, minimum 1.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `NoC`  in  16: active core count. 0 is treated as 1; values above `N_CORES` are clamped to `N_CORES`.
- `req`  in  `N_CORES`: per-core request.
- `we`  in  `N_CORES`: per-core write enable.
- `addr`  in  `N_CORES*AW`: per-core address; core i occupies bits [i*AW +: AW].
- `wdata`  in  `N_CORES*DW`: per-core write data, packed the same way.
- `gnt`  out  `N_CORES`: one-hot, one-cycle pulse when a request is accepted.
- `rvalid`  out  `N_CORES`: one-hot, one-cycle completion pulse, for reads and writes.
- `rdata`  out  `DW`: shared read data, valid while any `rvalid` bit is high.
- `mem_en`, `mem_we`  out  1: memory strobe and write enable, both one-cycle.
- `mem_addr`  out  `AW`; `mem_wdata`  out  `DW`; `mem_rdata`  in  `DW`.
- `busy`  out  1: high whenever the state is not IDLE.

## Operation
- FSM states and transitions:
  - IDLE: if any masked request is pending, go to ISSUE; otherwise stay in IDLE.
  - ISSUE: go to WAIT.
  - WAIT: stay for `MEM_LAT` cycles, then go to RESP.
  - RESP: go to IDLE.
- Masking: `req[i]` is eligible only when i < effective `NoC`.
- Arbitration happens in IDLE only. The search starts at `(last+1) mod N_CORES`, wraps, and takes the first eligible index as winner `w`. `we`, `addr` and `wdata` of `w` are latched, and `last` is set to `w`.
- ISSUE: `gnt[w]`=1 and `mem_en`=1. `mem_we`, `mem_addr` and `mem_wdata` are driven from the latched values.
- WAIT: a down-counter loaded with `MEM_LAT-1`. `mem_rdata` is registered on the last WAIT cycle.
- RESP: `rvalid[w]`=1.
  - Read: `rdata` carries the registered `mem_rdata`.
  - Write: `rdata` holds its previous value.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt`.
  - After `gnt`, the requester may drop `req` or keep it high to request again.
  - Dropping `req` before `gnt` is legal; requests are sampled only in IDLE.
- `NoC` changes take effect at the next IDLE arbitration. An in-flight access always completes.
- Reset values: `last`=`N_CORES-1`, so core 0 wins first. `gnt`, `rvalid`, `mem_en`, `mem_we`, `busy` = 0. `mem_addr`, `mem_wdata`, `rdata` = 0. State = IDLE.
- Reset mid-access: the FSM returns to IDLE on the reset edge. The access is dropped and no `rvalid` is issued for it.

## Timing
- With a request sampled in IDLE at cycle t:
  - `gnt` and `mem_en` in cycle t+1.
  - `mem_rdata` sampled at the end of cycle t+1+`MEM_LAT`.
  - `rvalid` in cycle t+2+`MEM_LAT`.
  - IDLE again in cycle t+3+`MEM_LAT`.
- Back-to-back accesses are spaced `MEM_LAT`+3 cycles apart. With `MEM_LAT`=2, grants arrive every 5 cycles.
- At most one `gnt` bit, one `rvalid` bit and one `mem_en` pulse are high per access.
- No combinational path from `req` to `gnt` or `mem_*`; all outputs are registered.

## Configuration
- `DMEM_ARB_BUSY_CNT_EN` defined:
  - Adds output port `busy_cycles`, 32 bits.
  - It increments every cycle `busy`=1, saturates at 0xFFFFFFFF, and clears on `rst`.
- `DMEM_ARB_BUSY_CNT_EN` undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
All scenarios use `N_CORES`=4, `MEM_LAT`=2, `NoC`=4 unless stated.
- Single read: `rst` pulse, then `req`=0001, `addr0`=0x0010, `mem_rdata`=0xBEEF. Expect `gnt`=0001 one cycle after the IDLE sample, `mem_addr`=0x0010 with `mem_we`=0, and `rvalid`=0001 with `rdata`=0xBEEF three cycles after `gnt`.
- Round-robin: `req`=1111 held high. Expect grant order 0,1,2,3,0 with grants 5 cycles apart, and exactly one `rvalid` per grant.
- Masking: `NoC`=2, `req`=1100 held high. Expect no `gnt` and `busy`=0. Then set `NoC`=4; expect the next grant to go to core 2.
- Write: `req`=0010, `we`=0010, `addr1`=0x0004, `wdata1`=0x1234. Expect `mem_en`=`mem_we`=1, `mem_addr`=0x0004, `mem_wdata`=0x1234, then `rvalid`=0010 with `rdata` unchanged.
- Reset mid-access: assert `rst` in the first WAIT cycle. Expect all outputs 0 on the next cycle, no `rvalid`, and core 0 winning first afterwards.
- With `DMEM_ARB_BUSY_CNT_EN` defined, `req`=0001 for one access: expect `busy_cycles`=4.
